// File: rtl/unidade_controle_jogo_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo_pkg
//
// Shared definitions for the memory-game controller: the state encoding
// (the codes are visible on db_estado and are also used by the game top level
// and the bench), the bundle of Moore control/status outputs, and the decoder
// that maps a state to its outputs.
// -----------------------------------------------------------------------------
package unidade_controle_jogo_pkg;

    // State codes are fixed; they are observed externally through db_estado.
    typedef enum logic [3:0] {
        Inicial      = 4'b0000,
        Preparacao   = 4'b0001,
        EsperaJogada = 4'b0010,
        Registra     = 4'b0100,
        Comparacao   = 4'b0101,
        Proximo      = 4'b0110,
        FimAcertou   = 4'b1010,
        FimErrou     = 4'b1110,
        FimTimeout   = 4'b1101
    } estado_e;

    localparam int unsigned EstadoWidth = 4;

    // Control outputs towards fluxo_dados plus the round status flags.
    typedef struct packed {
        logic zera_c;
        logic zera_r;
        logic registra_r;
        logic conta_c;
        logic pronto;
        logic acertou;
        logic errou;
        logic db_timeout;
    } saidas_t;

    localparam saidas_t SaidasNulas = '0;

    // Moore output decoder: every output depends on the state alone.
    function automatic saidas_t decodifica_saidas(input estado_e estado);
        saidas_t s;
        s = SaidasNulas;
        case (estado)
            Preparacao: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            Registra: begin
                s.registra_r = 1'b1;
            end
            Proximo: begin
                s.conta_c = 1'b1;
            end
            FimAcertou: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FimErrou: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            FimTimeout: begin
                s.pronto     = 1'b1;
                s.errou      = 1'b1;
                s.db_timeout = 1'b1;
            end
            default: begin
                s = SaidasNulas;
            end
        endcase
        return s;
    endfunction

    // Terminal states share the same restart behaviour.
    function automatic logic estado_terminal(input estado_e estado);
        return (estado == FimAcertou) || (estado == FimErrou) || (estado == FimTimeout);
    endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//
// Moore controller for the memory-game datapath. It walks one round of plays:
// clear the datapath, wait for a play, register it, compare it with the ROM,
// advance the address, and finish in win / wrong play / timeout.
//
// Ports
//   clock               in  system clock, rising edge
//   reset               in  synchronous active-high reset, forces Inicial
//   iniciar             in  start request (level)
//   jogada_feita        in  one-cycle play pulse from the datapath
//   chavesIgualMemoria  in  registered play equals ROM word
//   fimC                in  address counter at its last address
//   timeout             in  play-timeout flag from the datapath
//   zeraC               out clear address counter
//   zeraR               out clear play register and timeout counter
//   registraR           out load play register
//   contaC              out increment address counter
//   pronto              out round finished
//   acertou             out round won
//   errou               out round lost (wrong play or timeout)
//   db_timeout          out round lost by timeout
//   db_estado           out current state code
// -----------------------------------------------------------------------------
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   jogada_feita,
    input  logic                   chavesIgualMemoria,
    input  logic                   fimC,
    input  logic                   timeout,
    output logic                   zeraC,
    output logic                   zeraR,
    output logic                   registraR,
    output logic                   contaC,
    output logic                   pronto,
    output logic                   acertou,
    output logic                   errou,
    output logic                   db_timeout,
    output logic [EstadoWidth-1:0] db_estado
);

    estado_e estado_q;
    estado_e estado_d;
    saidas_t saidas_q;

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            Inicial: begin
                if (iniciar) begin
                    estado_d = Preparacao;
                end
            end
            Preparacao: begin
                estado_d = EsperaJogada;
            end
            EsperaJogada: begin
                // A timeout takes priority over a play arriving in the same cycle.
                if (timeout) begin
                    estado_d = FimTimeout;
                end else if (jogada_feita) begin
                    estado_d = Registra;
                end
            end
            Registra: begin
                estado_d = Comparacao;
            end
            Comparacao: begin
                // Mismatch is checked first so a wrong last play is an error.
                if (!chavesIgualMemoria) begin
                    estado_d = FimErrou;
                end else if (fimC) begin
                    estado_d = FimAcertou;
                end else begin
                    estado_d = Proximo;
                end
            end
            Proximo: begin
                estado_d = EsperaJogada;
            end
            FimAcertou, FimErrou, FimTimeout: begin
                if (iniciar) begin
                    estado_d = Preparacao;
                end
            end
            default: begin
                // Unused codes recover to the idle state.
                estado_d = Inicial;
            end
        endcase
    end

    // State register with registered Moore outputs. The outputs are decoded
    // from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= Inicial;
            saidas_q <= SaidasNulas;
        end else begin
            estado_q <= estado_d;
            saidas_q <= decodifica_saidas(estado_d);
        end
    end

    assign zeraC      = saidas_q.zera_c;
    assign zeraR      = saidas_q.zera_r;
    assign registraR  = saidas_q.registra_r;
    assign contaC     = saidas_q.conta_c;
    assign pronto     = saidas_q.pronto;
    assign acertou    = saidas_q.acertou;
    assign errou      = saidas_q.errou;
    assign db_timeout = saidas_q.db_timeout;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogo
//
// Directed scenarios for the game controller. The driver applies one input
// vector per cycle and queues the state code expected after the next edge;
// the monitor pops each expectation on the falling edge and compares
// db_estado and all eight outputs against the values for that state.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogo;

    localparam logic [3:0] SIni  = 4'b0000;
    localparam logic [3:0] SPrep = 4'b0001;
    localparam logic [3:0] SEsp  = 4'b0010;
    localparam logic [3:0] SReg  = 4'b0100;
    localparam logic [3:0] SComp = 4'b0101;
    localparam logic [3:0] SProx = 4'b0110;
    localparam logic [3:0] SAc   = 4'b1010;
    localparam logic [3:0] SErr  = 4'b1110;
    localparam logic [3:0] STo   = 4'b1101;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       timeout;
    logic       zeraC;
    logic       zeraR;
    logic       registraR;
    logic       contaC;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int n_conta = 0;
    int n_registra = 0;
    int n_zera = 0;

    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    unidade_controle_jogo dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada_feita       (jogada_feita),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .timeout            (timeout),
        .zeraC              (zeraC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .contaC             (contaC),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .db_timeout         (db_timeout),
        .db_estado          (db_estado)
    );

    // Expected {zeraC,zeraR,registraR,contaC,pronto,acertou,errou,db_timeout}.
    function automatic logic [7:0] saidas_esperadas(input logic [3:0] e);
        case (e)
            SPrep:   return 8'b1100_0000;
            SReg:    return 8'b0010_0000;
            SProx:   return 8'b0001_0000;
            SAc:     return 8'b0000_1100;
            SErr:    return 8'b0000_1010;
            STo:     return 8'b0000_1011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Monitor: compares every queued expectation and counts control pulses.
    always @(negedge clock) begin
        logic [3:0]  e;
        logic [11:0] got;
        logic [11:0] want;
        if (contaC) n_conta++;
        if (registraR) n_registra++;
        if (zeraC && zeraR) n_zera++;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            got  = {db_estado, zeraC, zeraR, registraR, contaC, pronto, acertou, errou,
                    db_timeout};
            want = {e, saidas_esperadas(e)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL estado/saidas at %0t: got %b required %b", $time, got, want);
            end
        end
    end

    // One cycle: drive inputs, wait for the edge, queue the state expected after it.
    task automatic passo(input logic rst, input logic ini, input logic jf, input logic ig,
                         input logic fc, input logic to, input logic [3:0] esperado);
        reset              = rst;
        iniciar            = ini;
        jogada_feita       = jf;
        chavesIgualMemoria = ig;
        fimC               = fc;
        timeout            = to;
        @(posedge clock);
        exp_q.push_back(esperado);
        #1;
    endtask

    task automatic inicia_rodada();
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SPrep);
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEsp);
    endtask

    // One play: pulse, register, compare, then the state chosen by the comparison.
    task automatic jogada(input logic igual, input logic ultimo);
        logic [3:0] fim;
        passo(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SReg);
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SComp);
        fim = !igual ? SErr : (ultimo ? SAc : SProx);
        passo(1'b0, 1'b0, 1'b0, igual, ultimo, 1'b0, fim);
        if (fim == SProx) passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEsp);
    endtask

    task automatic confere_contagem(input string nome, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nome, got, want);
        end
    endtask

    task automatic espera_monitor();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int base_c;
        int base_r;
        int base_z;

        // Reset, then idle: iniciar low and a stray timeout keep Inicial.
        passo(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, SIni);
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SIni);
        passo(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SIni);

        // Full correct round of 16 plays.
        espera_monitor();
        base_c = n_conta;
        base_r = n_registra;
        inicia_rodada();
        // Idle cycles in EsperaJogada do nothing.
        passo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEsp);
        for (int i = 0; i < 16; i++) jogada(1'b1, i == 15);
        // Terminal hold: timeout ignored.
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SAc);
        passo(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SAc);
        espera_monitor();
        confere_contagem("contaC pulses full round", n_conta - base_c, 15);
        confere_contagem("registraR pulses full round", n_registra - base_r, 16);

        // Restart from FimAcertou; wrong third play.
        base_c = n_conta;
        base_z = n_zera;
        inicia_rodada();
        jogada(1'b1, 1'b0);
        jogada(1'b1, 1'b0);
        jogada(1'b0, 1'b0);
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SErr);
        espera_monitor();
        confere_contagem("contaC pulses wrong 3rd", n_conta - base_c, 2);
        confere_contagem("zera pulses on restart", n_zera - base_z, 1);

        // Restart from FimErrou; timeout wins over a simultaneous play.
        inicia_rodada();
        jogada(1'b1, 1'b0);
        passo(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, STo);
        passo(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, STo);

        // Restart from FimTimeout; mismatch at the last address is an error.
        inicia_rodada();
        for (int i = 0; i < 15; i++) jogada(1'b1, 1'b0);
        jogada(1'b0, 1'b1);

        // iniciar held high in a terminal state keeps restarting.
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SPrep);
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SEsp);
        passo(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SReg);
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SComp);
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SErr);
        passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SPrep);

        // Reset in Comparacao: back to Inicial and no resume without iniciar.
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEsp);
        passo(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SReg);
        passo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SComp);
        passo(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SIni);
        passo(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SIni);
        passo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SIni);

        // Reset in a terminal state with iniciar high still lands in Inicial.
        inicia_rodada();
        passo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, STo);
        passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SIni);

        espera_monitor();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
